// File: rtl/ts_packet_scheduler_pkg.sv
// rtl/ts_packet_scheduler_pkg.sv - shared constants, FSM encoding and helpers for the TS packet scheduler
// Contents:
//   PKT_LEN_DEFAULT  default payload bytes per transport-stream packet
//   HDR_BYTES        per-source header bytes sent ahead of each packet
//   NUM_SRC          number of tuner sources sharing the output stream
//   state_t          scheduler FSM states
//   sat_inc          saturating 32-bit increment used by the byterate counters
package ts_packet_scheduler_pkg;

    localparam int PKT_LEN_DEFAULT = 188;
    localparam int HDR_BYTES       = 4;
    localparam int NUM_SRC         = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
        return (en && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
    endfunction

endpackage

// File: rtl/ts_packet_scheduler_if.sv
// rtl/ts_packet_scheduler_if.sv - source FIFO and output byte-stream bundle for the TS packet scheduler
// Signals:
//   src_pkt_ready[3:0]  FIFO i holds at least one complete packet
//   src_mask[3:0]       source i eligible for grant
//   src_rd[3:0]         one-hot FIFO read strobe
//   src_data[31:0]      FIFO i byte on [8i+7:8i], one cycle after src_rd[i]
//   out_data[7:0]       output byte
//   out_valid           out_data valid
//   out_sop             first header byte of a packet
//   out_ready           downstream accepts the byte
// Modports: master = scheduler side, slave = FIFOs + serialiser side.
interface ts_packet_scheduler_if;

    logic [3:0]  src_pkt_ready;
    logic [3:0]  src_mask;
    logic [3:0]  src_rd;
    logic [31:0] src_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_sop;
    logic        out_ready;

    modport master (
        input  src_pkt_ready, src_mask, src_data, out_ready,
        output src_rd, out_data, out_valid, out_sop
    );

    modport slave (
        output src_pkt_ready, src_mask, src_data, out_ready,
        input  src_rd, out_data, out_valid, out_sop
    );

endinterface

// File: rtl/ts_packet_scheduler_rr_arbiter4.sv
// rtl/ts_packet_scheduler_rr_arbiter4.sv - combinational 4-way round-robin pick
// Ports:
//   elig[3:0]        requesting sources
//   last_grant[1:0]  most recently granted source (lowest priority)
//   grant[1:0]       first eligible source searching upward from last_grant+1
//   valid            at least one source eligible
module rr_arbiter4 (
    input  logic [3:0] elig,
    input  logic [1:0] last_grant,
    output logic [1:0] grant,
    output logic       valid
);

    // Walk candidates from farthest (last_grant itself) to nearest
    // (last_grant+1); the last hit written wins, so the nearest one is kept.
    always_comb begin
        grant = last_grant;
        valid = 1'b0;
        for (int i = 4; i >= 1; i--) begin
            if (elig[last_grant + 2'(i)]) begin
                grant = last_grant + 2'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ts_packet_scheduler.sv
// rtl/ts_packet_scheduler.sv - round-robin TS packet scheduler feeding the ASI output byte stream
// Parameters:
//   PKT_LEN        payload bytes per packet (8-bit read counter)
//   WINDOW_CYCLES  byterate measurement window in CLK cycles
// Ports:
//   CLK, RST           clock, asynchronous active-low reset
//   bus                source FIFO + output stream bundle (master side)
//   header_byte_addr   header store address {grant, k}
//   header_byte        header store data, combinational from address
//   byterate_bus       per-source byte count of the last window, source i on [32i+31:32i]
// Build option: define BYTERATE_EN to generate the per-source byterate counters;
// otherwise byterate_bus is tied to zero.
module ts_packet_scheduler
    import ts_packet_scheduler_pkg::*;
#(
    parameter int PKT_LEN       = PKT_LEN_DEFAULT,
    parameter int WINDOW_CYCLES = 27_000_000
) (
    input  logic                 CLK,
    input  logic                 RST,
    ts_packet_scheduler_if.master bus,
    output logic [3:0]           header_byte_addr,
    input  logic [7:0]           header_byte,
    output logic [127:0]         byterate_bus
);

    localparam logic [1:0] K_LAST   = 2'(HDR_BYTES - 1);
    localparam logic [7:0] RD_TOTAL = 8'(PKT_LEN);
    localparam logic [7:0] LD_LAST  = 8'(PKT_LEN - 1);

    state_t      state, state_n;
    logic [1:0]  grant, last_grant, k;
    logic [7:0]  rd_cnt, ld_cnt;
    logic        inflight;
    logic        skid_valid, skid_valid_n;
    logic [7:0]  skid_data, skid_data_n;

    logic [3:0]  elig;
    logic [1:0]  arb_grant;
    logic        arb_valid;

    logic        load_ok, hdr_load, pay_load, load, prefetch, issue_rd;
    logic [7:0]  arrive, pay_byte, ld_byte;
    logic        ld_sop;

    assign elig = bus.src_pkt_ready & bus.src_mask;

    rr_arbiter4 u_arb (
        .elig       (elig),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    always_comb begin
        load_ok      = !bus.out_valid || bus.out_ready;
        hdr_load     = (state == HDR) && load_ok;
        arrive       = bus.src_data[{grant, 3'b000} +: 8];
        pay_load     = (state == PAY) && load_ok && (skid_valid || inflight);
        pay_byte     = skid_valid ? skid_data : arrive;
        load         = hdr_load || pay_load;
        ld_byte      = hdr_load ? header_byte : pay_byte;
        ld_sop       = hdr_load && (k == 2'd0);

        // The skid buffer catches a returning byte that cannot enter the
        // output register; a read is only issued if the skid will be empty
        // next cycle, so the byte it fetches always has somewhere to land.
        skid_valid_n = skid_valid;
        skid_data_n  = skid_data;
        if (skid_valid) begin
            if (load_ok) begin
                skid_valid_n = inflight;
                skid_data_n  = arrive;
            end
        end else if (inflight && !load_ok) begin
            skid_valid_n = 1'b1;
            skid_data_n  = arrive;
        end

        // First payload read is launched alongside the last header byte so
        // p0 arrives just as h3 leaves; this keeps header and payload on
        // consecutive output cycles.
        prefetch     = hdr_load && (k == K_LAST);
        issue_rd     = prefetch ||
                       ((state == PAY) && (rd_cnt < RD_TOTAL) && !skid_valid_n);
    end

    assign bus.src_rd       = issue_rd ? (4'b0001 << grant) : 4'b0000;
    assign header_byte_addr = (state == HDR) ? {grant, k} : 4'd0;

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (arb_valid) state_n = HDR;
            HDR:  if (hdr_load && (k == K_LAST)) state_n = PAY;
            PAY:  if (pay_load && (ld_cnt == LD_LAST)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            grant         <= 2'd0;
            last_grant    <= 2'd3;
            k             <= 2'd0;
            rd_cnt        <= 8'd0;
            ld_cnt        <= 8'd0;
            inflight      <= 1'b0;
            skid_valid    <= 1'b0;
            skid_data     <= 8'd0;
            bus.out_data  <= 8'd0;
            bus.out_valid <= 1'b0;
            bus.out_sop   <= 1'b0;
        end else begin
            if ((state == IDLE) && arb_valid) begin
                grant      <= arb_grant;
                last_grant <= arb_grant;
                k          <= 2'd0;
                rd_cnt     <= 8'd0;
                ld_cnt     <= 8'd0;
            end
            if (hdr_load) k <= k + 2'd1;
            if (issue_rd) rd_cnt <= rd_cnt + 8'd1;
            if (pay_load) ld_cnt <= ld_cnt + 8'd1;
            inflight   <= issue_rd;
            skid_valid <= skid_valid_n;
            skid_data  <= skid_data_n;

            if (load) begin
                bus.out_data  <= ld_byte;
                bus.out_sop   <= ld_sop;
                bus.out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

`ifdef BYTERATE_EN
    localparam logic [31:0] WIN_LAST = 32'(WINDOW_CYCLES - 1);

    logic [31:0] win_cnt;
    logic [1:0]  out_src;
    logic [31:0] cnt  [NUM_SRC];
    logic [31:0] rate [NUM_SRC];
    logic        xfer;

    assign xfer = bus.out_valid && bus.out_ready;

    // The output register can still hold the previous packet's last byte
    // after grant has moved on, so the owner travels with the byte.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_src <= 2'd0;
            win_cnt <= 32'd0;
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt[i]  <= 32'd0;
                rate[i] <= 32'd0;
            end
        end else begin
            if (load) out_src <= grant;
            win_cnt <= (win_cnt == WIN_LAST) ? 32'd0 : win_cnt + 32'd1;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (win_cnt == WIN_LAST) begin
                    rate[i] <= sat_inc(cnt[i], xfer && (out_src == 2'(i)));
                    cnt[i]  <= 32'd0;
                end else begin
                    cnt[i]  <= sat_inc(cnt[i], xfer && (out_src == 2'(i)));
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_rate
        assign byterate_bus[32*g +: 32] = rate[g];
    end
`else
    assign byterate_bus = 128'd0;
`endif

endmodule
